// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-cache memory responder with word RAM and board MMIO window
`timescale 1ns/1ps

module data_mem_responder #(
    parameter int          ADDR_BITS = 14,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_F000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MemAddr,
    input  logic [31:0] MemWriteData,
    input  logic        MemWe,
    output logic [31:0] MemData,
    input  logic [15:0] Switch,
    input  logic [4:0]  Button,
    output logic [15:0] Led,
    output logic [31:0] SegData
);

    // MMIO register word offsets (MemAddr[11:2])
    localparam logic [9:0] OFF_LED    = 10'h000;
    localparam logic [9:0] OFF_SEG    = 10'h001;
    localparam logic [9:0] OFF_SWITCH = 10'h002;
    localparam logic [9:0] OFF_BUTTON = 10'h003;
    localparam logic [9:0] OFF_STICKY = 10'h004;
    localparam logic [9:0] OFF_WRCNT  = 10'h005;
    localparam logic [9:0] OFF_CYCCNT = 10'h006;

    logic [31:0] r_ram [0:(1 << ADDR_BITS) - 1];

    logic [15:0] r_led;
    logic [31:0] r_seg;
    logic [15:0] r_sw_s1;
    logic [15:0] r_sw_s2;
    logic [4:0]  r_btn_s1;
    logic [4:0]  r_btn_s2;
    logic [4:0]  r_btn_prev;
    logic [4:0]  r_btn_sticky;
    logic [31:0] r_wr_count;
    logic [31:0] r_cyc_count;

    logic                 w_is_mmio;
    logic                 w_is_ram;
    logic [ADDR_BITS-1:0] w_word;
    logic [9:0]           w_off;
    logic                 w_wr_ram;
    logic                 w_wr_mmio;
    logic                 w_wr_mapped;
    logic [4:0]           w_btn_rise;
    logic [4:0]           w_sticky_clr;
    logic [31:0]          w_rd_data;
    logic                 w_unused_addr_lsb;

    // Byte lane bits are ignored; every access is a whole word.
    assign w_unused_addr_lsb = &{1'b0, MemAddr[1:0]};

    assign w_is_mmio   = (MemAddr[31:12] == MMIO_BASE[31:12]);
    assign w_is_ram    = ~|MemAddr[31:ADDR_BITS+2];
    assign w_word      = MemAddr[ADDR_BITS+1:2];
    assign w_off       = MemAddr[11:2];

    assign w_wr_ram    = MemWe & w_is_ram;
    assign w_wr_mmio   = MemWe & w_is_mmio;
    assign w_wr_mapped = w_wr_ram | w_wr_mmio;

    // A rise is seen one edge after the synchronised level goes high.
    assign w_btn_rise   = r_btn_s2 & ~r_btn_prev;
    assign w_sticky_clr = (w_wr_mmio && (w_off == OFF_STICKY)) ? MemWriteData[4:0] : 5'd0;

    assign Led     = r_led;
    assign SegData = r_seg;
    assign MemData = w_rd_data;

    // Combinational read decode: RAM word, MMIO register, or zero for unmapped/write-only.
    always_comb begin
        w_rd_data = 32'd0;
        if (w_is_ram) begin
            w_rd_data = r_ram[w_word];
        end else if (w_is_mmio) begin
            case (w_off)
                OFF_LED:    w_rd_data = {16'd0, r_led};
                OFF_SEG:    w_rd_data = r_seg;
                OFF_SWITCH: w_rd_data = {16'd0, r_sw_s2};
                OFF_BUTTON: w_rd_data = {27'd0, r_btn_s2};
                OFF_STICKY: w_rd_data = {27'd0, r_btn_sticky};
                OFF_WRCNT:  w_rd_data = r_wr_count;
                OFF_CYCCNT: w_rd_data = r_cyc_count;
                default:    w_rd_data = 32'd0;
            endcase
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[w_word] <= MemWriteData;
        end
    end

    // Writable MMIO registers (LED and seven-segment value).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led <= 16'd0;
            r_seg <= 32'd0;
        end else if (w_wr_mmio) begin
            if (w_off == OFF_LED) begin
                r_led <= MemWriteData[15:0];
            end
            if (w_off == OFF_SEG) begin
                r_seg <= MemWriteData;
            end
        end
    end

    // Two-flop synchronisers for switches and buttons, plus the edge-detect history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sw_s1    <= 16'd0;
            r_sw_s2    <= 16'd0;
            r_btn_s1   <= 5'd0;
            r_btn_s2   <= 5'd0;
            r_btn_prev <= 5'd0;
        end else begin
            r_sw_s1    <= Switch;
            r_sw_s2    <= r_sw_s1;
            r_btn_s1   <= Button;
            r_btn_s2   <= r_btn_s1;
            r_btn_prev <= r_btn_s2;
        end
    end

    // Sticky press bits: write-1-to-clear, a simultaneous new press keeps the bit set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_sticky <= 5'd0;
        end else begin
            r_btn_sticky <= (r_btn_sticky & ~w_sticky_clr) | w_btn_rise;
        end
    end

    // Count every accepted write to RAM or MMIO; dropped unmapped writes do not count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_count <= 32'd0;
        end else if (w_wr_mapped) begin
            r_wr_count <= r_wr_count + 32'd1;
        end
    end

    // Free-running cycle counter since reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc_count <= 32'd0;
        end else begin
            r_cyc_count <= r_cyc_count + 32'd1;
        end
    end

endmodule
